// File: rtl/sccb_apb_master.sv
// sccb_apb_master: APB3 slave with a command FIFO that runs queued
// SCCB register writes and 2+2-phase reads at a programmable SIO_C rate.
module sccb_apb_master #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RST    = 250
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [4:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        sio_c,
    output logic        sio_d_oe,
    input  logic        sio_d_in,
    output logic        pwdn,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        IDLE, START, BIT_LO, BIT_HI, STOP_LO, STOP_HI, STOP_REL, GAP
    } state_t;

    state_t        state, state_n;
    logic [23:0]   mem [FIFO_DEPTH];
    logic [LW-1:0] wp, rp, level;
    logic [15:0]   div, div_l, cnt;
    logic [3:0]    bcnt;
    logic [2:0]    ph;
    logic [23:0]   cur;
    logic [7:0]    rx, rdata, byte_c;
    logic          en, irq_en, rd_valid, ovf, s1, s2;
    logic [2:0]    a;
    logic          acc, wr, rd, unmapped, empty, full, busy;
    logic          pop, push_req, push, drop, flush;
    logic          tick_end, bit_v, phase_last, done_rd;
    logic          unused;

    assign unused = &{1'b0, PWDATA[30:24], PWDATA[16], PADDR[1:0]};

    assign a        = PADDR[4:2];
    assign acc      = PSEL & PENABLE;
    assign wr       = acc & PWRITE;
    assign rd       = acc & ~PWRITE;
    assign unmapped = (a > 3'd4);
    assign level    = wp - rp;
    assign empty    = (wp == rp);
    assign full     = (level == LW'(FIFO_DEPTH));
    assign busy     = (state != IDLE);
    assign flush    = wr & (a == 3'd4) & PWDATA[1];
    assign pop      = (state == IDLE) & en & ~empty & ~flush;
    assign push_req = wr & (a == 3'd0);
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    assign PREADY   = 1'b1;
    assign PSLVERR  = acc & (unmapped | drop);
    assign irq      = irq_en & empty & ~busy;
    assign tick_end = (cnt == div_l - 16'd1);

    // byte of the current phase; phase 3 is the sensor's data byte
    always_comb begin
        case (ph)
            3'd0:    byte_c = {cur[22:16], 1'b0};
            3'd1:    byte_c = cur[15:8];
            3'd2:    byte_c = cur[23] ? {cur[22:16], 1'b1} : cur[7:0];
            default: byte_c = 8'hFF;
        endcase
    end

    assign bit_v      = bcnt[3] | byte_c[~bcnt[2:0]];
    assign phase_last = cur[23] ? (ph == 3'd1 || ph == 3'd3)
                                : (ph == 3'd2);
    assign done_rd    = (state == GAP) & tick_end & cur[23]
                      & (ph == 3'd4);

    always_comb begin
        state_n  = state;
        sio_c    = 1'b1;
        sio_d_oe = 1'b0;
        case (state)
            IDLE: if (pop) state_n = START;
            START: begin
                sio_d_oe = 1'b1;
                if (tick_end) state_n = BIT_LO;
            end
            BIT_LO: begin
                sio_c    = 1'b0;
                sio_d_oe = ~bit_v;
                if (tick_end) state_n = BIT_HI;
            end
            BIT_HI: begin
                sio_d_oe = ~bit_v;
                if (tick_end)
                    state_n = (bcnt[3] && phase_last) ? STOP_LO : BIT_LO;
            end
            STOP_LO: begin
                sio_c    = 1'b0;
                sio_d_oe = 1'b1;
                if (tick_end) state_n = STOP_HI;
            end
            STOP_HI: begin
                sio_d_oe = 1'b1;
                if (tick_end) state_n = STOP_REL;
            end
            STOP_REL: if (tick_end) state_n = GAP;
            GAP: if (tick_end)
                state_n = (cur[23] && ph == 3'd2) ? START : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state <= IDLE;
            cnt   <= '0;
            bcnt  <= '0;
            ph    <= '0;
            cur   <= '0;
            div_l <= 16'd2;
            rx    <= '0;
            s1    <= 1'b1;
            s2    <= 1'b1;
        end else begin
            state <= state_n;
            s1    <= sio_d_in;
            s2    <= s1;
            if (state == IDLE) begin
                cnt <= '0;
                if (pop) begin
                    cur   <= mem[rp[AW-1:0]];
                    div_l <= (div < 16'd2) ? 16'd2 : div;
                    ph    <= '0;
                    bcnt  <= '0;
                end
            end else if (tick_end) begin
                cnt <= '0;
                if (state == BIT_HI) begin
                    if (bcnt[3]) begin
                        bcnt <= '0;
                        ph   <= ph + 3'd1;
                    end else begin
                        bcnt <= bcnt + 4'd1;
                    end
                end
            end else begin
                cnt <= cnt + 16'd1;
            end
            if (state == BIT_HI && tick_end && ph == 3'd3 && !bcnt[3])
                rx <= {rx[6:0], s2};
        end
    end

    always_ff @(posedge PCLK) begin
        if (push) mem[wp[AW-1:0]] <= {PWDATA[31], PWDATA[23:17],
                                      PWDATA[15:8], PWDATA[7:0]};
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            div      <= 16'(DIV_RST);
            en       <= 1'b0;
            irq_en   <= 1'b0;
            pwdn     <= 1'b0;
            wp       <= '0;
            rp       <= '0;
            ovf      <= 1'b0;
            rd_valid <= 1'b0;
            rdata    <= '0;
        end else begin
            if (wr && a == 3'd3) div <= PWDATA[15:0];
            if (wr && a == 3'd4) begin
                en     <= PWDATA[0];
                irq_en <= PWDATA[2];
                pwdn   <= PWDATA[3];
            end
            if (flush) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (push) wp <= wp + LW'(1);
                if (pop)  rp <= rp + LW'(1);
            end
            if (drop) ovf <= 1'b1;
            else if (wr && a == 3'd1 && PWDATA[4]) ovf <= 1'b0;
            // a completing read beats a same-cycle clear
            if (done_rd) begin
                rd_valid <= 1'b1;
                rdata    <= rx;
            end else if ((wr && a == 3'd1 && PWDATA[3]) ||
                         (rd && a == 3'd2)) begin
                rd_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        case (a)
            3'd1: PRDATA = {16'd0, {(8-LW){1'b0}}, level, 3'd0,
                            ovf, rd_valid, full, empty, busy};
            3'd2: PRDATA = {24'd0, rdata};
            3'd3: PRDATA = {16'd0, div};
            3'd4: PRDATA = {28'd0, pwdn, irq_en, 1'b0, en};
            default: PRDATA = '0;
        endcase
    end
endmodule

// File: tb/tb_sccb_apb_master.sv
// tb_sccb_apb_master: bus-level decode of SIO_C/SIO_D with a sensor
// model, table and random vectors, and multi-cycle corner sequences.
module tb_sccb_apb_master;
    logic        PCLK = 1'b0, PRESETN = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [4:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR, sio_c, sio_d_oe, sio_d_in, pwdn, irq;
    logic        sensor_low = 1'b0;

    assign sio_d_in = ~(sio_d_oe | sensor_low);
    always #5 PCLK = ~PCLK;

    sccb_apb_master #(.FIFO_DEPTH(8), .DIV_RST(250)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .sio_c(sio_c), .sio_d_oe(sio_d_oe), .sio_d_in(sio_d_in),
        .pwdn(pwdn), .irq(irq)
    );

    int vecs = 0, errs = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // bus monitor and sensor
    logic       pc = 1'b1, pd = 1'b1, pirq = 1'b0, frame_rd = 1'b0;
    logic       d;
    logic [7:0] sh = '0, resp = '0;
    int cyc = 0, n = 0, rises = 0, starts = 0, irq_rises = 0, t_irq = 0;
    int t_starts[$];
    logic [7:0] bytes_q[$];

    always @(negedge PCLK) begin
        cyc++;
        d = ~(sio_d_oe | sensor_low);
        if (pc && sio_c && pd && !d) begin
            starts++;
            t_starts.push_back(cyc);
            n = 0;
            frame_rd = 1'b0;
        end else if (!pc && sio_c) begin
            rises++;
            if (n % 9 < 8) sh = {sh[6:0], d};
            if (n % 9 == 7) bytes_q.push_back(sh);
            if (n == 7) frame_rd = d;
            n++;
        end else if (pc && !sio_c) begin
            if (frame_rd && n >= 9 && n <= 16) sensor_low = ~resp[16-n];
            else sensor_low = 1'b0;
        end
        if (!PRESETN) begin
            sensor_low = 1'b0;
            frame_rd = 1'b0;
            n = 0;
        end
        if (irq && !pirq) begin
            irq_rises++;
            t_irq = cyc;
        end
        pirq = irq;
        pc = sio_c;
        pd = ~(sio_d_oe | sensor_low);
    end

    task automatic apb(input logic w, input logic [4:0] a,
                       input logic [31:0] wd, output logic [31:0] r,
                       output logic e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = wd;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1;
        r = PRDATA;
        e = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] wd);
        logic [31:0] r;
        logic e;
        apb(1'b1, a, wd, r, e);
    endtask

    task automatic rdr(input logic [4:0] a, output logic [31:0] r);
        logic e;
        apb(1'b0, a, 32'd0, r, e);
    endtask

    task automatic wait_irq(input int base, input int limit,
                            input string nm);
        int k = 0;
        while (irq_rises == base && k < limit) begin
            @(posedge PCLK);
            k++;
        end
        chk({nm, " irq"}, 32'(irq_rises != base), 32'd1);
    endtask

    task automatic wait_starts(input int target, input int limit);
        int k = 0;
        while (starts < target && k < limit) begin
            @(posedge PCLK);
            k++;
        end
        chk("start seen", 32'(starts >= target), 32'd1);
    endtask

    typedef struct {
        logic [31:0] cmd;
        logic [15:0] div;
        logic [7:0]  resp;
        int          nb;
        logic [31:0] eb;
        int          dur;
        int          nr;
    } vec_t;

    // expected bus traffic from the protocol rules
    function automatic vec_t model(input logic [31:0] cmd,
                                   input logic [15:0] dv,
                                   input logic [7:0] rs);
        vec_t v;
        int t;
        logic [7:0] idw;
        t = (dv < 16'd2) ? 2 : int'(dv);
        idw = {cmd[23:17], 1'b0};
        v.cmd = cmd; v.div = dv; v.resp = rs;
        if (cmd[31]) begin
            v.nb = 4;
            v.eb = {idw, cmd[15:8], idw | 8'h01, rs};
            v.dur = t * 2 * (1 + 2 * 18 + 4);
            v.nr = 2 * (18 + 1);
        end else begin
            v.nb = 3;
            v.eb = {idw, cmd[15:8], cmd[7:0], 8'h00};
            v.dur = t * (1 + 2 * 27 + 4);
            v.nr = 27 + 1;
        end
        return v;
    endfunction

    vec_t tv[10];
    logic [31:0] r;
    logic        e;
    int          s0, b0, q0, r0;

    initial begin
        tv[0] = '{32'h0042_1280, 16'd4, 8'h00, 3, 32'h4212_8000, 236, 28};
        tv[1] = '{32'h8042_0A00, 16'd4, 8'h76, 4, 32'h420A_4376, 328, 38};
        tv[2] = '{32'h00F0_55AA, 16'd0, 8'h00, 3, 32'hF055_AA00, 118, 28};
        tv[3] = '{32'h80FF_33C5, 16'd3, 8'h81, 4, 32'hFE33_FF81, 246, 38};
        for (int i = 4; i < 10; i++)
            tv[i] = model($urandom, 16'($urandom_range(0, 5)),
                          8'($urandom));

        #2;
        chk("rst sio_c", 32'(sio_c), 32'd1);
        chk("rst oe", 32'(sio_d_oe), 32'd0);
        chk("rst irq", 32'(irq), 32'd0);
        chk("rst pwdn", 32'(pwdn), 32'd0);
        chk("rst pslverr", 32'(PSLVERR), 32'd0);
        chk("rst prdata", PRDATA, 32'd0);
        #20;
        PRESETN = 1'b1;
        rdr(5'h04, r); chk("rst status", r, 32'h2);
        rdr(5'h0C, r); chk("rst div", r, 32'd250);
        rdr(5'h10, r); chk("rst ctrl", r, 32'd0);
        rdr(5'h08, r); chk("rst rdata", r, 32'd0);
        apb(1'b0, 5'h14, 32'd0, r, e); chk("unmapped rd err", 32'(e), 1);
        apb(1'b1, 5'h1C, 32'hFFFF_FFFF, r, e);
        chk("unmapped wr err", 32'(e), 1);
        apb(1'b0, 5'h0C, 32'd0, r, e); chk("mapped rd err", 32'(e), 0);
        wr(5'h10, 32'h8);
        chk("pwdn", 32'(pwdn), 32'd1);
        wr(5'h10, 32'h5);
        rdr(5'h00, r); chk("cmd reads 0", r, 32'd0);

        for (int i = 0; i < 10; i++) begin
            wr(5'h0C, {16'd0, tv[i].div});
            resp = tv[i].resp;
            s0 = starts; b0 = bytes_q.size(); q0 = irq_rises; r0 = rises;
            wr(5'h00, tv[i].cmd);
            wait_irq(q0, tv[i].dur * 2 + 200, $sformatf("v%0d", i));
            chk($sformatf("v%0d nbytes", i), 32'(bytes_q.size() - b0),
                32'(tv[i].nb));
            for (int j = 0; j < tv[i].nb; j++)
                if (b0 + j < bytes_q.size())
                    chk($sformatf("v%0d byte%0d", i, j),
                        32'(bytes_q[b0+j]), 32'(tv[i].eb[31-8*j -: 8]));
            chk($sformatf("v%0d dur", i), 32'(t_irq - t_starts[s0]),
                32'(tv[i].dur));
            chk($sformatf("v%0d rises", i), 32'(rises - r0),
                32'(tv[i].nr));
            if (tv[i].cmd[31]) begin
                rdr(5'h04, r); chk("rd_valid set", 32'(r[3]), 32'd1);
                rdr(5'h08, r); chk("rdata", r, 32'(tv[i].resp));
                rdr(5'h04, r); chk("rd_valid clr", 32'(r[3]), 32'd0);
            end
        end

        // overflow with the queue held off
        wr(5'h10, 32'h4);
        wr(5'h0C, 32'd2);
        b0 = bytes_q.size(); s0 = starts;
        for (int i = 0; i < 9; i++) begin
            apb(1'b1, 5'h00, {8'h00, 7'(7'h10 + 7'(i)), 1'b0,
                8'(i * 3), 8'(8'hA0 + i)}, r, e);
            chk($sformatf("ovf push%0d err", i), 32'(e),
                32'(i == 8));
        end
        rdr(5'h04, r); chk("ovf status", r, 32'h0814);
        wr(5'h04, 32'h10);
        rdr(5'h04, r); chk("ovf w1c", r, 32'h0804);
        q0 = irq_rises;
        wr(5'h10, 32'h5);
        wait_irq(q0, 4000, "ovf drain");
        chk("ovf starts", 32'(starts - s0), 32'd8);
        chk("ovf nbytes", 32'(bytes_q.size() - b0), 32'd24);
        for (int i = 0; i < 8; i++) begin
            vec_t v;
            v = model({8'h00, 7'(7'h10 + 7'(i)), 1'b0, 8'(i * 3),
                       8'(8'hA0 + i)}, 16'd2, 8'h00);
            for (int j = 0; j < 3; j++)
                if (b0 + 3 * i + j < bytes_q.size())
                    chk($sformatf("ovf t%0d b%0d", i, j),
                        32'(bytes_q[b0+3*i+j]), 32'(v.eb[31-8*j -: 8]));
        end

        // flush during the first of four
        wr(5'h0C, 32'd4);
        s0 = starts; b0 = bytes_q.size(); q0 = irq_rises;
        for (int i = 0; i < 4; i++) wr(5'h00, 32'h0030_0100 + 32'(i));
        wait_starts(s0 + 1, 100);
        wr(5'h10, 32'h7);
        wait_irq(q0, 600, "flush");
        repeat (300) @(posedge PCLK);
        chk("flush starts", 32'(starts - s0), 32'd1);
        chk("flush nbytes", 32'(bytes_q.size() - b0), 32'd3);
        rdr(5'h04, r); chk("flush status", r, 32'h2);
        rdr(5'h10, r); chk("flush self-clear", r, 32'h5);

        // disable mid-transaction
        s0 = starts;
        for (int i = 0; i < 3; i++) wr(5'h00, 32'h0030_0200 + 32'(i));
        wait_starts(s0 + 1, 100);
        wr(5'h10, 32'h4);
        repeat (400) @(posedge PCLK);
        chk("dis starts", 32'(starts - s0), 32'd1);
        rdr(5'h04, r); chk("dis status", r, 32'h0200);
        wr(5'h10, 32'h6);
        rdr(5'h04, r); chk("dis flushed", r, 32'h2);

        // DIV change while busy
        wr(5'h10, 32'h5);
        s0 = starts; q0 = irq_rises;
        wr(5'h00, 32'h0044_0011);
        wr(5'h00, 32'h0044_0022);
        wait_starts(s0 + 1, 100);
        wr(5'h0C, 32'd10);
        wait_irq(q0, 2000, "div chg");
        chk("div chg t1", 32'(t_starts[s0+1] - t_starts[s0]),
            32'(59 * 4 + 1));
        chk("div chg t2", 32'(t_irq - t_starts[s0+1]), 32'(59 * 10));

        // asynchronous reset during the read data phase
        wr(5'h0C, 32'd4);
        resp = 8'h5A;
        s0 = starts;
        wr(5'h00, 32'h8042_0A00);
        begin
            int k = 0;
            while (!(starts >= s0 + 2 && n >= 12) && k < 400) begin
                @(posedge PCLK);
                k++;
            end
            chk("data phase", 32'(starts >= s0 + 2 && n >= 12), 32'd1);
        end
        #3;
        PRESETN = 1'b0;
        PADDR = 5'h04;
        #1;
        chk("mid rst sio_c", 32'(sio_c), 32'd1);
        chk("mid rst oe", 32'(sio_d_oe), 32'd0);
        chk("mid rst irq", 32'(irq), 32'd0);
        chk("mid rst status", PRDATA, 32'h2);
        PADDR = 5'h0C;
        #1;
        chk("mid rst div", PRDATA, 32'd250);
        PADDR = 5'h00;
        repeat (3) @(posedge PCLK);
        #1;
        PRESETN = 1'b1;
        repeat (400) @(posedge PCLK);
        chk("no resume", 32'(starts - s0), 32'd2);
        rdr(5'h04, r); chk("post rst status", r, 32'h2);
        rdr(5'h10, r); chk("post rst ctrl", r, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
